serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only while ready=1.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands, captured on the accepted-start edge.
REQ-006 The block SHALL have port c_in, input, 1 bit: the carry-in, captured on the accepted-start edge.
REQ-007 The block SHALL have port ready, output, 1 bit: high while in IDLE.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in ADD.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port c_out, output, 1 bit: the registered carry-out.

Function
REQ-012 The block SHALL compute {c_out,sum} = a + b + c_in, using one 1-bit full-adder cell time-shared LSB-first over WIDTH cycles.
REQ-013 The FSM SHALL have states IDLE, ADD and DONE, with transitions IDLE->ADD on start=1, ADD->DONE after the WIDTH-th bit, DONE->IDLE unconditionally.
REQ-014 On an accepted start edge the block SHALL load operand shift registers from a and b, load the carry flop from c_in, clear the bit counter and clear the sum shift register.
REQ-015 On each edge in ADD the block SHALL:
  - shift the cell sum bit into the MSB of the sum register, shifting right;
  - load the carry flop with the cell carry;
  - shift both operand registers right;
  - increment the bit counter.
REQ-016 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, and the ADD->DONE transition SHALL occur on the edge where counter = WIDTH-1.
REQ-017 Latency: with start accepted at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH, and ready SHALL return after edge k+WIDTH+1.
REQ-018 sum and c_out SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-019 start SHALL be ignored in ADD and DONE, with no effect on state, operands or counter.
REQ-020 A change on a, b or c_in after the accepted start edge SHALL NOT affect the result.
REQ-021 ready, busy and done SHALL be one-hot at all times outside reset.
REQ-022 Back-to-back operation: a start asserted continuously SHALL be accepted on the first edge in IDLE after DONE, giving one result every WIDTH+2 cycles.
REQ-023 The carry out of bit WIDTH-1 SHALL appear on c_out with no truncation, and overflow wrap SHALL be reflected only in sum.

Reset
REQ-024 While reset_b=0 the block SHALL asynchronously force:
  - state=IDLE;
  - ready=1, busy=0, done=0;
  - sum=0, c_out=0;
  - operand registers, carry flop and counter to 0.
REQ-025 When reset_b is asserted mid-ADD the block SHALL abandon the operation, produce no done pulse, and behave as if freshly reset after reset release.
REQ-026 The first edge after reset_b deasserts SHALL be able to accept start.

Structure
REQ-027 A shared package SHALL hold the state typedef (IDLE=2'b00, ADD=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-028 The 1-bit combinational full adder SHALL be a separate sub-module, add_full_cell (sum, c_out, a, b, c_in), instantiated once, with no delays.
REQ-029 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Verification
REQ-030 With WIDTH=8, a=8'h5A, b=8'h3C, c_in=0 and start pulsed: done SHALL be high exactly 8 cycles after the start edge, with sum=8'h96 and c_out=0.
REQ-031 a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; then a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
REQ-032 start re-pulsed at ADD cycle 3 with different operands, and a/b toggled during ADD -> the original result is unchanged, exactly one done pulse occurs, and the extra start is dropped.
REQ-033 reset_b pulsed low at ADD cycle 4 -> immediately ready=1, busy=0, sum=0, c_out=0, no done pulse; a following start completes correctly.
REQ-034 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart, each with the correct sum.
REQ-035 Random a, b, c_in over 1000 operations -> {c_out,sum} matches the reference model, and ready/busy/done stay one-hot throughout.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_cell.sv
// Single-bit combinational full adder, time-shared by serial_add_ctrl.
module add_full_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {c_out,sum} = a + b + c_in, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | ready for start; result registers hold last answer
// ADD   | one full-adder step per edge, WIDTH edges in total
// DONE  | single-cycle done pulse, result valid
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic w_sum;
  logic w_carry;

  add_full_cell u_cell (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry),
    .sum   (w_sum),
    .c_out (w_carry)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ADD;
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ADD: begin
          // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
          r_sum   <= {w_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_carry;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_state <= DONE;
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule
